// File: rtl/montador_senha_pkg.sv
// Shared types for the keypad entry path of the electronic lock.
// Attempt buffer layout and key-code constants.
package montador_senha_pkg;

    localparam int MAX_DIGITOS = 20;
    localparam int MIN_DIGITOS = 4;

    localparam logic [3:0] TECLA_LIMPA  = 4'hA;
    localparam logic [3:0] TECLA_ENTRA  = 4'hB;
    localparam logic [3:0] DIGITO_VAZIO = 4'hF;

    // digit i lives in [i]; [0] is the oldest digit held
    typedef logic [MAX_DIGITOS-1:0][3:0] senhaPac_t;

    function automatic senhaPac_t senha_vazia();
        return {MAX_DIGITOS{DIGITO_VAZIO}};
    endfunction

endpackage

// File: rtl/montador_senha_if.sv
// Keypad-to-checker bundle for the password assembler.
// master drives keys and completion, slave is the assembler.
interface montador_senha_if;
    import montador_senha_pkg::*;

    logic       key_valid;
    logic [3:0] key_code;
    logic       verif_done;
    senhaPac_t  senha_teste;
    logic       senha_valid;
    logic [4:0] num_digitos;
    logic       ocupado;
    logic       timeout;
    logic       entrada_invalida;

    modport master (
        output key_valid, key_code, verif_done,
        input  senha_teste, senha_valid, num_digitos,
        input  ocupado, timeout, entrada_invalida
    );

    modport slave (
        input  key_valid, key_code, verif_done,
        output senha_teste, senha_valid, num_digitos,
        output ocupado, timeout, entrada_invalida
    );

endinterface

// File: rtl/montador_senha_temporizador.sv
// Saturating inactivity timer shared by the lock timeouts.
// expirou flags the last idle cycle before the limit.
module temporizador_inatividade #(
    parameter int CICLOS = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic enable,
    output logic expirou
);

    localparam int W = $clog2(CICLOS + 1);
    localparam logic [W-1:0] LIM = W'(CICLOS - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || reload || !enable) begin
            cnt <= '0;
        end else if (cnt != LIM) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expirou = enable && (cnt == LIM);

endmodule

// File: rtl/montador_senha.sv
// Keypad entry assembler feeding the password checker.
// Buffers digits, submits on '#', holds the attempt until done.
module montador_senha
    import montador_senha_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    montador_senha_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        COLETA,
        SUBMIT,
        ESPERA
    } estado_t;

    estado_t    estado, estado_d;
    senhaPac_t  digitos, digitos_d;
    logic [4:0] conta, conta_d;
    logic       valid_q, valid_d;
    logic       to_q, to_d;
    logic       inv_q, inv_d;
    logic       ocup_q, ocup_d;
    logic       key_acc;
    logic       expirou;
    logic       eh_digito;

    assign eh_digito = bus.key_code <= 4'd9;

    always_comb begin
        estado_d  = estado;
        digitos_d = digitos;
        conta_d   = conta;
        valid_d   = 1'b0;
        to_d      = 1'b0;
        inv_d     = 1'b0;
        key_acc   = 1'b0;
        unique case (estado)
            IDLE, COLETA: begin
                if (bus.key_valid && eh_digito) begin
                    key_acc  = 1'b1;
                    estado_d = COLETA;
                    if (conta < 5'(MAX_DIGITOS)) begin
                        digitos_d[conta] = bus.key_code;
                        conta_d = conta + 5'd1;
                    end else begin
                        for (int i = 0; i < MAX_DIGITOS - 1; i++)
                            digitos_d[i] = digitos[i+1];
                        digitos_d[MAX_DIGITOS-1] = bus.key_code;
                    end
                end else if (bus.key_valid &&
                             bus.key_code == TECLA_LIMPA) begin
                    key_acc   = 1'b1;
                    estado_d  = IDLE;
                    digitos_d = senha_vazia();
                    conta_d   = '0;
                end else if (bus.key_valid &&
                             bus.key_code == TECLA_ENTRA) begin
                    key_acc = 1'b1;
                    if (conta >= 5'(MIN_DIGITOS)) begin
                        estado_d = SUBMIT;
                        valid_d  = 1'b1;
                    end else begin
                        inv_d     = 1'b1;
                        estado_d  = IDLE;
                        digitos_d = senha_vazia();
                        conta_d   = '0;
                    end
                end else if (estado == COLETA && expirou) begin
                    to_d      = 1'b1;
                    estado_d  = IDLE;
                    digitos_d = senha_vazia();
                    conta_d   = '0;
                end
            end
            SUBMIT: estado_d = ESPERA;
            ESPERA: begin
                // completion beats a coincident timeout
                if (bus.verif_done || expirou) begin
                    to_d      = !bus.verif_done;
                    estado_d  = IDLE;
                    digitos_d = senha_vazia();
                    conta_d   = '0;
                end
            end
            default: estado_d = IDLE;
        endcase
        ocup_d = (estado_d == SUBMIT) || (estado_d == ESPERA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= IDLE;
            digitos <= senha_vazia();
            conta   <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            inv_q   <= 1'b0;
            ocup_q  <= 1'b0;
        end else begin
            estado  <= estado_d;
            digitos <= digitos_d;
            conta   <= conta_d;
            valid_q <= valid_d;
            to_q    <= to_d;
            inv_q   <= inv_d;
            ocup_q  <= ocup_d;
        end
    end

    temporizador_inatividade #(
        .CICLOS(TIMEOUT_CICLOS)
    ) u_tempo (
        .clk    (clk),
        .rst    (rst),
        .reload (key_acc || (estado_d != estado)),
        .enable ((estado == COLETA) || (estado == ESPERA)),
        .expirou(expirou)
    );

    assign bus.senha_teste      = digitos;
    assign bus.senha_valid      = valid_q;
    assign bus.num_digitos      = conta;
    assign bus.ocupado          = ocup_q;
    assign bus.timeout          = to_q;
    assign bus.entrada_invalida = inv_q;

endmodule

// File: doc/montador_senha.md
Name: montador_senha

Overview:
Keypad-entry assembler for the electronic lock; it is the stage directly upstream of the password checker.
- Collects decoded key presses into a senhaPac_t buffer, with unused digits filled with 4'hF.
- On '#', issues a one-cycle valid pulse carrying the assembled attempt.
- Holds the attempt stable until the checker reports done.
- Handles clear, short-entry rejection, overflow (keeps the last 20 digits) and inactivity timeout.

Parameters:
MAX_DIGITOS, 20, buffer depth in digits; equals the digit count of senhaPac_t.
MIN_DIGITOS, 4, minimum digits accepted on '#'.
TIMEOUT_CICLOS, 50_000_000, idle cycles before the entry is discarded.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
key_valid  in  1  one-cycle pulse: key_code is a new press
key_code  in  4  0-9 = digit, 4'hA = '*' (clear), 4'hB = '#' (submit), others ignored
verif_done  in  1  checker finished (drives return to idle)
senha_teste  out  senhaPac_t  assembled attempt
senha_valid  out  1  one-cycle pulse; connects to the checker's valid_in
num_digitos  out  5  digits currently held, 0..MAX_DIGITOS
ocupado  out  1  high in SUBMIT and ESPERA; key presses are ignored while high
timeout  out  1  one-cycle pulse: entry discarded by inactivity
entrada_invalida  out  1  one-cycle pulse: '#' pressed with fewer than MIN_DIGITOS digits

Behaviour:
Clock and reset
- Single clock domain; reset is synchronous and active-high.
- Reset values: all digits = 4'hF, num_digitos = 0, all pulses = 0, ocupado = 0, timer = 0, state = IDLE.
- rst asserted in any state, including mid-ESPERA, aborts the operation with no pulse emitted.
- All outputs are registered.

States
- IDLE: buffer empty.
- COLETA: one or more digits held.
- SUBMIT: senha_valid high for exactly this one cycle.
- ESPERA: waiting for verif_done.

Digit key (0-9), in IDLE or COLETA
- If num_digitos < MAX_DIGITOS: write to digits[num_digitos], increment count, go to COLETA.
- If full: shift digits[i] <= digits[i+1] for i = 0..18, write the new digit to digits[19], count stays 20.
- digits[0] is always the oldest held digit.

'*' key
- In COLETA: clear buffer to all 4'hF, count 0, go to IDLE.
- In IDLE: no effect.

'#' key
- In COLETA with count >= MIN_DIGITOS: go to SUBMIT. Key on edge N gives senha_valid = 1 during cycle N+1, then ESPERA from N+2.
- With count < MIN_DIGITOS, including IDLE: pulse entrada_invalida for one cycle, clear buffer, go to IDLE.

Holding and completion
- senha_teste is held unchanged through SUBMIT and ESPERA, because the checker reads it over several cycles.
- ESPERA with verif_done = 1: clear buffer, go to IDLE on the next edge.
- verif_done outside ESPERA is ignored.
- key_valid while ocupado is dropped; nothing is queued.

Timer
- Active in COLETA and ESPERA; reloads to 0 on every accepted key and on every state entry.
- When the timer reaches TIMEOUT_CICLOS-1 with no key that cycle: pulse timeout, clear buffer, go to IDLE.
- In ESPERA, timeout also releases ocupado; this covers a checker that never finishes.
- A key arriving in the same cycle as expiry wins: the key is processed and the timer reloads.
- Counter width is $clog2(TIMEOUT_CICLOS+1); it saturates and never wraps.
- IDLE does not time out.

Width rules
- num_digitos is 5 bits and saturates at MAX_DIGITOS.
- Shift and write indices stay within 0..MAX_DIGITOS-1.

Decomposition:
Shared types package (Tipos):
- senhaPac_t (MAX_DIGITOS nibble digits, unused = 4'hF).
- Key-code constants: TECLA_LIMPA = 4'hA, TECLA_ENTRA = 4'hB, DIGITO_VAZIO = 4'hF.
- The state enum stays local to the module.

Sub-module: one natural sub-module, temporizador_inatividade.
- Ports: clk, rst, reload, enable, expirou.
- Reused by other lock timeouts.
- The shift buffer stays inline.

Test Plan:
1. Reset, keys 1,2,3,4,# -> num_digitos = 4 before '#'; one senha_valid pulse with digits[0..3] = 1,2,3,4 and [4..19] = F; ocupado = 1 until verif_done pulse; the cycle after that, buffer is all F, count 0, IDLE.
2. Keys 7,8,9,# -> entrada_invalida pulses once, no senha_valid, count 0. Then '#' in IDLE -> entrada_invalida again.
3. Digits 0..9, 0..9, 5, 6 (22 keys), then # -> count saturates at 20; senha_teste = 2..9, 0..9, 5, 6; senha_valid pulses once.
4. TIMEOUT_CICLOS = 16: key 3, then 16 idle cycles -> timeout pulses exactly 16 cycles after the key, buffer cleared. Repeat with a key landing on the expiry cycle -> no timeout, count 2.
5. Keys during ESPERA (digit, '*', '#') -> senha_teste unchanged, no pulses. verif_done pulse while in COLETA -> ignored, count unchanged.
6. rst asserted for 1 cycle in ESPERA -> next cycle all outputs at reset values, no senha_valid, timeout or entrada_invalida; fresh 1,2,3,4,# works normally.
